mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO registers.
- Sits beside the ALU and decoder. The decoder flags a mul/div instruction; this block accepts it, iterates for 32 cycles, then writes HI/LO.
- Raises stall_req while a dependent instruction (MFHI/MFLO/MTHI/MTLO or another start) must wait.
- Operands are the low 32 bits of 64-bit register values. Results are sign-extended to 64 bits, matching MIPS64 word ops.

Parameters:
- XLEN, 64, register/HI/LO width.
- OPW, 32, operand width and iteration count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  decoder presents a mul/div this cycle
- op  in  2  muldiv_op_t: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  XLEN  source A (bits [31:0] used)
- rt_val  in  XLEN  source B (bits [31:0] used)
- hilo_rd  in  1  MFHI/MFLO in decode
- mthi  in  1  write HI from wdata
- mtlo  in  1  write LO from wdata
- wdata  in  XLEN  MTHI/MTLO data
- flush  in  1  abort in-flight op (exception/ERET)
- busy  out  1  operation in flight
- stall_req  out  1  hold decode/fetch
- done  out  1  one-cycle pulse, HI/LO just updated
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal regs 0.
- FSM states: IDLE, ITER, FIXUP.
- IDLE + start at edge T0:
  - Latch op and operand magnitudes; signed ops take abs values, record result signs.
  - Counter=31, go to ITER.
- ITER: one shift-add (mul) or restoring shift-subtract (div) step per cycle. At counter==0, go to FIXUP; otherwise decrement.
- FIXUP: apply sign correction.
  - Quotient negative iff operand signs differ.
  - Remainder takes the dividend sign.
  - At the exit edge, write hi/lo, each as a 32-bit result sign-extended to XLEN. Assert done for the following cycle. Go to IDLE.
- Latency: busy high for 33 cycles after accept. done high in cycle 34 after T0, coinciding with the new hi/lo values. A new start is accepted in that same cycle.
- MULT/MULTU: {hi32,lo32} = 64-bit product.
- DIV/DIVU: lo32 = quotient truncated toward zero, hi32 = remainder.
- Divide by zero: lo32=0xFFFFFFFF, hi32=dividend low 32 bits.
- DIV 0x80000000 / 0xFFFFFFFF: lo32=0x80000000, hi32=0, no trap.
- stall_req = busy & (start | hilo_rd | mthi | mtlo). It is combinational.
- start while busy is ignored; the stalled instruction re-presents it.
- mthi/mtlo in IDLE write at the edge. If start arrives in the same cycle, the write is applied and the op still launches; its result later overwrites.
- mthi/mtlo while busy are ignored (stalled).
- flush has priority over everything:
  - Any state goes to IDLE, busy=0, done=0.
  - hi/lo are unchanged.
  - A start in the flush cycle is dropped.
- reset mid-operation: same as reset values; no done pulse.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: at accept, if (mul and either operand==0) or (div and divisor==0), skip ITER and go straight to FIXUP.
  - busy is high for 1 cycle; done is high in cycle 2.
  - Results are identical to the iterative path.
- Undefined: every op takes full 33-cycle busy latency.

Decomposition:
- structures package:
  - muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - muldiv_state_t enum (MD_IDLE, MD_ITER, MD_FIXUP).
  - Constant MULDIV_ITERS=32.
- Sub-module mips_muldiv_step: combinational single-iteration datapath (add/shift or subtract/shift, selected by a mul/div bit). The FSM, counter, HI/LO and sign fixup stay in the top module.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) -> busy 33 cycles, done cycle 34; hi=0xFFFFFFFFFFFFFFFF, lo=0xFFFFFFFFFFFFFFEB.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFFFFFFFFFE, lo=0x0000000000000001.
- DIV -7/2 -> lo=0xFFFFFFFFFFFFFFFD, hi=0xFFFFFFFFFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0xFFFFFFFF80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFFFFFFFFFF, hi=5. With MULDIV_FAST_ZERO_EN, done in cycle 2.
- During busy, assert hilo_rd, mthi, and start in turn -> stall_req=1 each cycle. hi/lo and the in-flight op are unaffected. Repeat in IDLE -> stall_req=0 and mthi(0x1234) writes hi=0x1234 next cycle.
- Start MULT, flush at cycle 10 with start also high -> IDLE next cycle, busy=0, no done, hi/lo hold prior values. Reset mid-op at cycle 20 -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/mips_muldiv_unit_pkg.sv
// rtl/mips_muldiv_unit_pkg.sv - shared types and constants for the HI/LO mul/div sequencer
package mips_muldiv_unit_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_ITER  = 2'b01,
        MD_FIXUP = 2'b10
    } muldiv_state_t;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// rtl/mips_muldiv_unit_if.sv - decoder-side bundle for the mul/div unit
interface mips_muldiv_unit_if
    import mips_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            start;
    muldiv_op_t      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            hilo_rd;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wdata;
    logic            flush;
    logic            busy;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hilo_rd, mthi, mtlo, wdata, flush,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hilo_rd, mthi, mtlo, wdata, flush,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit_step.sv
// rtl/mips_muldiv_unit_step.sv - one shift-add / restoring shift-subtract iteration
module mips_muldiv_step #(
    parameter int OPW = 32
) (
    input  logic             div_i,
    input  logic [2*OPW-1:0] acc_i,
    input  logic [OPW-1:0]   b_i,
    output logic [2*OPW-1:0] acc_o
);
    logic [OPW:0]   sum;
    logic [OPW:0]   rem_sh;
    logic [OPW-1:0] diff;
    logic           fits;

    // acc holds {partial, operand}: mul shifts right, div shifts left with quotient bits
    always_comb begin
        sum    = {1'b0, acc_i[2*OPW-1:OPW]} + {1'b0, (acc_i[0] ? b_i : {OPW{1'b0}})};
        rem_sh = acc_i[2*OPW-1:OPW-1];
        fits   = rem_sh >= {1'b0, b_i};
        diff   = rem_sh[OPW-1:0] - b_i;
        if (div_i) begin
            if (fits) begin
                acc_o = {diff, acc_i[OPW-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[OPW-1:0], acc_i[OPW-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[OPW-1:1]};
        end
    end
endmodule

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MULDIV_FAST_ZERO_EN skips iteration on zero operands
module mips_muldiv_unit
    import mips_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OPW  = MULDIV_ITERS
) (
    input logic               clk,
    input logic               reset,
    mips_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(OPW);

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*OPW-1:0] acc_q, acc_d;
    logic [OPW-1:0]   b_q, b_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;

    logic [OPW-1:0]   a_raw, b_raw, a_mag, b_mag;
    logic             op_signed, op_div;
    logic [2*OPW-1:0] step_acc, prod;
    logic [OPW-1:0]   quo_f, rem_f, res_hi, res_lo;
    logic             unused_hi;

    assign a_raw     = bus.rs_val[OPW-1:0];
    assign b_raw     = bus.rt_val[OPW-1:0];
    assign op_signed = is_signed_op(bus.op);
    assign op_div    = is_div_op(bus.op);
    assign a_mag     = (op_signed && a_raw[OPW-1]) ? -a_raw : a_raw;
    assign b_mag     = (op_signed && b_raw[OPW-1]) ? -b_raw : b_raw;
    assign unused_hi = ^{bus.rs_val[XLEN-1:OPW], bus.rt_val[XLEN-1:OPW]};

    mips_muldiv_step #(.OPW(OPW)) u_step (
        .div_i (is_div_q),
        .acc_i (acc_q),
        .b_i   (b_q),
        .acc_o (step_acc)
    );

    // Magnitude results are corrected here; divide-by-zero forces an all-ones quotient
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quo_f  = div0_q ? {OPW{1'b1}} : (neg_q ? -acc_q[OPW-1:0] : acc_q[OPW-1:0]);
        rem_f  = rem_neg_q ? -acc_q[2*OPW-1:OPW] : acc_q[2*OPW-1:OPW];
        res_hi = is_div_q ? rem_f : prod[2*OPW-1:OPW];
        res_lo = is_div_q ? quo_f : prod[OPW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (bus.mthi) hi_d = bus.wdata;
                if (bus.mtlo) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d   = MD_ITER;
                    cnt_d     = CW'(OPW - 1);
                    acc_d     = {{OPW{1'b0}}, a_mag};
                    b_d       = b_mag;
                    is_div_d  = op_div;
                    neg_d     = op_signed && (a_raw[OPW-1] ^ b_raw[OPW-1]);
                    rem_neg_d = op_signed && a_raw[OPW-1];
                    div0_d    = op_div && (b_raw == '0);
`ifdef MULDIV_FAST_ZERO_EN
                    // Preload exactly what the full iteration would have produced
                    if (op_div ? (b_raw == '0) : ((a_raw == '0) || (b_raw == '0))) begin
                        state_d = MD_FIXUP;
                        acc_d   = op_div ? {a_mag, {OPW{1'b1}}} : '0;
                    end
`endif
                end
            end
            MD_ITER: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = MD_FIXUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MD_FIXUP: begin
                hi_d    = {{(XLEN-OPW){res_hi[OPW-1]}}, res_hi};
                lo_d    = {{(XLEN-OPW){res_lo[OPW-1]}}, res_lo};
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (bus.flush) begin
            state_d = MD_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy      = (state_q != MD_IDLE);
    assign bus.stall_req = bus.busy & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - randomized self-checking bench for mips_muldiv_unit
module tb_mips_muldiv_unit;
    import mips_muldiv_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [63:0] exp_hi, exp_lo;

    mips_muldiv_unit_if #(.XLEN(64)) bus ();

    mips_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] h, output logic [63:0] l);
        logic [31:0] h32, l32;
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        h32 = '0;
        l32 = '0;
        case (op)
            2'd0: begin sp = longint'(sa) * longint'(sb); {h32, l32} = sp; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; {h32, l32} = up; end
            2'd2: begin
                if (b == 32'd0) begin l32 = 32'hFFFF_FFFF; h32 = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l32 = a; h32 = 32'd0; end
                else begin l32 = sa / sb; h32 = sa % sb; end
            end
            default: begin
                if (b == 32'd0) begin l32 = 32'hFFFF_FFFF; h32 = a; end
                else begin l32 = a / b; h32 = a % b; end
            end
        endcase
        h = sext(h32);
        l = sext(l32);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = 34;
`ifdef MULDIV_FAST_ZERO_EN
        if (op[1] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) lat = 2;
`endif
        return lat;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.op     = muldiv_op_t'(op);
        bus.rs_val = {$urandom(), a};
        bus.rt_val = {$urandom(), b};
    endtask

    task automatic release_start();
        bus.start  = 1'b0;
        bus.rs_val = {$urandom(), $urandom()};
        bus.rt_val = {$urandom(), $urandom()};
    endtask

    task automatic finish_op(input int cyc0, input int lat, input logic [63:0] eh, input logic [63:0] el);
        int cyc;
        cyc = cyc0;
        while (!bus.done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("hi", bus.hi, eh);
        check("lo", bus.lo, el);
        exp_hi = eh;
        exp_lo = el;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] eh, el;
        model(op, a, b, eh, el);
        present(op, a, b);
        tick();
        release_start();
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        finish_op(1, exp_lat(op, a, b), eh, el);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] eh, el;
        int cyc, n_done;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = MD_MULT; bus.rs_val = '0; bus.rt_val = '0;
        bus.hilo_rd = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", bus.hi, 64'd0);
        check("reset_lo", bus.lo, 64'd0);
        exp_hi = '0;
        exp_lo = '0;

        run_op(2'd0, 32'd7, 32'hFFFF_FFFD);
        check("mult_hi_const", bus.hi, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mult_lo_const", bus.lo, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        check("done_one_cycle", 64'(bus.done), 64'd0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi_const", bus.hi, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", bus.lo, 64'hFFFF_FFFF_8000_0000);
        run_op(2'd3, 32'd5, 32'd0);
        check("divu0_lo_const", bus.lo, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0);
        run_op(2'd0, 32'd0, 32'h1234_5678);

        // stall behaviour while busy: the in-flight MULT must be untouched
        model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, eh, el);
        present(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        tick();
        release_start();
        cyc = 1;
        tick(); cyc++;
        bus.hilo_rd = 1'b1;
        #1 check("stall_hilo_rd", 64'(bus.stall_req), 64'd1);
        tick(); cyc++;
        bus.hilo_rd = 1'b0;
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 64'hDEAD_BEEF_CAFE_F00D;
        #1 check("stall_mt", 64'(bus.stall_req), 64'd1);
        tick(); cyc++;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("busy_mthi_ignored", bus.hi, exp_hi);
        check("busy_mtlo_ignored", bus.lo, exp_lo);
        present(2'd3, 32'd100, 32'd3);
        #1 check("stall_start", 64'(bus.stall_req), 64'd1);
        tick(); cyc++;
        release_start();
        finish_op(cyc, 34, eh, el);

        bus.hilo_rd = 1'b1; bus.mthi = 1'b1; bus.wdata = 64'h1234;
        #1 check("idle_stall", 64'(bus.stall_req), 64'd0);
        tick();
        bus.hilo_rd = 1'b0; bus.mthi = 1'b0;
        check("idle_mthi", bus.hi, 64'h1234);
        exp_hi = 64'h1234;

        // MTLO together with start: written now, overwritten by the result
        bus.mtlo = 1'b1; bus.wdata = 64'h5555_AAAA_0000_7777;
        model(2'd3, 32'd100, 32'd7, eh, el);
        present(2'd3, 32'd100, 32'd7);
        tick();
        release_start();
        bus.mtlo = 1'b0;
        check("mtlo_with_start", bus.lo, 64'h5555_AAAA_0000_7777);
        finish_op(1, 34, eh, el);
        check("divu_lo_const", bus.lo, 64'd14);

        for (int i = 0; i < 16; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            run_op(rop, pick_operand(), pick_operand());
        end

        // flush at cycle 10 with a competing start
        present(2'd0, 32'h0BAD_F00D, 32'h7777_1111);
        tick();
        release_start();
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        bus.flush = 1'b1;
        present(2'd3, 32'd9, 32'd4);
        tick();
        bus.flush = 1'b0;
        release_start();
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done), 64'd0);
        check("flush_hi", bus.hi, exp_hi);
        check("flush_lo", bus.lo, exp_lo);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.done) n_done++; end
        check("flush_no_done", 64'(n_done), 64'd0);

        // synchronous reset mid-operation
        present(2'd2, 32'hFFFF_0000, 32'd3);
        tick();
        release_start();
        cyc = 1;
        while (cyc < 20) begin tick(); cyc++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_hi", bus.hi, 64'd0);
        check("rst_mid_lo", bus.lo, 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.done) n_done++; end
        check("rst_no_done", 64'(n_done), 64'd0);
        exp_hi = '0;
        exp_lo = '0;

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_hi_const", bus.hi, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
